// File: rtl/dso_pkg.sv
// Shared encodings for the scope capture datapath: FSM states, trigger modes, edge polarity.
package dso_pkg;

  typedef enum logic [1:0] {
    ST_PREFILL = 2'b00,
    ST_ARMED   = 2'b01,
    ST_POST    = 2'b10,
    ST_HOLD    = 2'b11
  } state_e;

  localparam logic [1:0] MODE_NORMAL = 2'b00;
  localparam logic [1:0] MODE_AUTO   = 2'b01;
  localparam logic [1:0] MODE_SINGLE = 2'b10;

  localparam logic EDGE_RISING  = 1'b0;
  localparam logic EDGE_FALLING = 1'b1;

endpackage

// File: rtl/capture_ram.sv
// Simple dual-port sample buffer: one synchronous write port, one registered read port.
// Read latency 1 cycle; no backpressure, write and read accepted every cycle.
module capture_ram #(
  parameter int DATA_W = 12,
  parameter int DEPTH  = 640,
  parameter int ADDR_W = 10
) (
  input  logic              clk_i,
  input  logic              we_i,
  input  logic [ADDR_W-1:0] waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [ADDR_W-1:0] raddr_i,
  output logic [DATA_W-1:0] rdata_o
);

  logic [DATA_W-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/multi_ch_trigger_capture.sv
// Single-channel triggered capture into a circular buffer with pre-trigger window, frozen in HOLD for display.
// Read data/row 1 cycle after rd_addr; no backpressure, strobes arriving in HOLD are dropped.
module multi_ch_trigger_capture
  import dso_pkg::*;
#(
  parameter int DATA_W       = 12,
  parameter int NUM_CH       = 8,
  parameter int CH_W         = 3,
  parameter int DEPTH        = 640,
  parameter int ADDR_W       = 10,
  parameter int PRE_TRIG     = 320,
  parameter int AUTO_TIMEOUT = 4096,
  parameter int SCREEN_H     = 480,
  parameter int Y_SHIFT      = 3
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_CH*DATA_W-1:0] ch_samples,
  input  logic                     sample_valid,
  input  logic [CH_W-1:0]          ch_sel,
  input  logic [DATA_W-1:0]        trig_level,
  input  logic                     trig_edge,
  input  logic [1:0]               mode,
  input  logic                     rearm,
  input  logic                     arm,
  input  logic [ADDR_W-1:0]        rd_addr,
  output logic [DATA_W-1:0]        rd_data,
  output logic [9:0]               rd_row,
  output logic [1:0]               state,
  output logic                     capture_done,
  output logic                     auto_trig
);

  localparam int POST_N  = DEPTH - PRE_TRIG - 1;
  localparam int TMO_W   = (AUTO_TIMEOUT > 1) ? $clog2(AUTO_TIMEOUT) : 1;
  localparam int ROW_MAX = SCREEN_H - 1;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [ADDR_W-1:0] PRE_LAST  = ADDR_W'(PRE_TRIG - 1);
  localparam logic [ADDR_W-1:0] POST_LAST = ADDR_W'((POST_N > 0) ? POST_N - 1 : 0);
  localparam logic [TMO_W-1:0]  TMO_LAST  = TMO_W'(AUTO_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_addr_q, wr_addr_d;
  logic [ADDR_W-1:0]   fill_q, fill_d;
  logic [ADDR_W-1:0]   post_q, post_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
  logic [DATA_W-1:0]   prev_q, prev_d;
  logic                prev_valid_q, prev_valid_d;
  logic                auto_trig_q, auto_trig_d;
  logic                done_q, done_d;
  logic [CH_W-1:0]     ch_q, ch_d;
  logic [DATA_W-1:0]   level_q, level_d;
  logic                edge_q, edge_d;
  logic [1:0]          mode_q, mode_d;
  logic                rd_zero_q;

  logic [DATA_W-1:0]   ch_arr [NUM_CH];
  logic [DATA_W-1:0]   cur;
  logic                edge_hit, tmo_hit, release_hold, ram_we;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    assign ch_arr[g] = ch_samples[g*DATA_W +: DATA_W];
  end
  assign cur = ch_arr[ch_q];

  always_comb begin
    edge_hit = 1'b0;
    case (edge_q)
      EDGE_RISING:  edge_hit = prev_valid_q && (prev_q < level_q) && (cur >= level_q);
      EDGE_FALLING: edge_hit = prev_valid_q && (prev_q > level_q) && (cur <= level_q);
      default:      edge_hit = 1'b0;
    endcase
    tmo_hit = (mode_q == MODE_AUTO) && (tmo_q == TMO_LAST);
    case (mode_q)
      MODE_SINGLE:            release_hold = arm;
      MODE_NORMAL, MODE_AUTO: release_hold = rearm;
      default:                release_hold = rearm;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    wr_addr_d    = wr_addr_q;
    fill_d       = fill_q;
    post_d       = post_q;
    tmo_d        = tmo_q;
    trig_addr_d  = trig_addr_q;
    prev_d       = prev_q;
    prev_valid_d = prev_valid_q;
    auto_trig_d  = auto_trig_q;
    done_d       = 1'b0;
    ch_d         = ch_q;
    level_d      = level_q;
    edge_d       = edge_q;
    mode_d       = mode_q;
    ram_we       = 1'b0;

    if ((state_q != ST_HOLD) && sample_valid) begin
      ram_we       = 1'b1;
      wr_addr_d    = (wr_addr_q == LAST_ADDR) ? '0 : wr_addr_q + 1'b1;
      prev_d       = cur;
      prev_valid_d = 1'b1;
    end

    case (state_q)
      ST_PREFILL: begin
        if (sample_valid) begin
          fill_d = fill_q + 1'b1;
          if (fill_q == PRE_LAST) state_d = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (sample_valid) begin
          if (edge_hit || tmo_hit) begin
            trig_addr_d = wr_addr_q;
            // A genuine edge on the timeout sample is reported as a real trigger.
            auto_trig_d = !edge_hit;
            post_d      = '0;
            if (POST_N == 0) begin
              state_d = ST_HOLD;
              done_d  = 1'b1;
            end else begin
              state_d = ST_POST;
            end
          end else if (tmo_q != TMO_LAST) begin
            tmo_d = tmo_q + 1'b1;
          end
        end
      end
      ST_POST: begin
        if (sample_valid) begin
          post_d = post_q + 1'b1;
          if (post_q == POST_LAST) begin
            state_d = ST_HOLD;
            done_d  = 1'b1;
          end
        end
      end
      ST_HOLD: begin
        if (release_hold) begin
          state_d      = ST_PREFILL;
          wr_addr_d    = '0;
          fill_d       = '0;
          post_d       = '0;
          tmo_d        = '0;
          prev_valid_d = 1'b0;
          ch_d         = ch_sel;
          level_d      = trig_level;
          edge_d       = trig_edge;
          mode_d       = mode;
        end
      end
      default: state_d = ST_PREFILL;
    endcase
  end

  logic              rd_oob;
  logic [ADDR_W+1:0] rd_sum;
  logic [ADDR_W-1:0] rd_phys;
  logic [DATA_W-1:0] ram_rdata;
  logic [DATA_W-1:0] rd_scaled;

  // Rotate the column index so column PRE_TRIG lands on the trigger sample.
  always_comb begin
    rd_oob = ({1'b0, rd_addr} >= (ADDR_W+1)'(DEPTH));
    rd_sum = {2'b00, trig_addr_q} + (ADDR_W+2)'(DEPTH - PRE_TRIG) + {2'b00, rd_addr};
    if (rd_sum >= (ADDR_W+2)'(2*DEPTH)) begin
      rd_sum = rd_sum - (ADDR_W+2)'(2*DEPTH);
    end else if (rd_sum >= (ADDR_W+2)'(DEPTH)) begin
      rd_sum = rd_sum - (ADDR_W+2)'(DEPTH);
    end
    rd_phys = rd_oob ? '0 : rd_sum[ADDR_W-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_PREFILL;
      wr_addr_q    <= '0;
      fill_q       <= '0;
      post_q       <= '0;
      tmo_q        <= '0;
      trig_addr_q  <= '0;
      prev_q       <= '0;
      prev_valid_q <= 1'b0;
      auto_trig_q  <= 1'b0;
      done_q       <= 1'b0;
      ch_q         <= ch_sel;
      level_q      <= trig_level;
      edge_q       <= trig_edge;
      mode_q       <= mode;
      rd_zero_q    <= 1'b1;
    end else begin
      state_q      <= state_d;
      wr_addr_q    <= wr_addr_d;
      fill_q       <= fill_d;
      post_q       <= post_d;
      tmo_q        <= tmo_d;
      trig_addr_q  <= trig_addr_d;
      prev_q       <= prev_d;
      prev_valid_q <= prev_valid_d;
      auto_trig_q  <= auto_trig_d;
      done_q       <= done_d;
      ch_q         <= ch_d;
      level_q      <= level_d;
      edge_q       <= edge_d;
      mode_q       <= mode_d;
      rd_zero_q    <= rd_oob;
    end
  end

  capture_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (ram_we),
    .waddr_i (wr_addr_q),
    .wdata_i (cur),
    .raddr_i (rd_phys),
    .rdata_o (ram_rdata)
  );

  always_comb begin
    rd_data   = rd_zero_q ? '0 : ram_rdata;
    rd_scaled = rd_data >> Y_SHIFT;
    if (32'(rd_scaled) >= 32'(ROW_MAX)) begin
      rd_row = '0;
    end else begin
      rd_row = 10'(ROW_MAX) - 10'(rd_scaled);
    end
  end

  assign state        = state_q;
  assign capture_done = done_q;
  assign auto_trig    = auto_trig_q;

endmodule

// File: tb/tb_multi_ch_trigger_capture.sv
// Bench for multi_ch_trigger_capture at DEPTH=16, PRE_TRIG=4, one sample strobe every 3rd clock.
module tb_multi_ch_trigger_capture;
  import dso_pkg::*;

  localparam int DATA_W = 12;
  localparam int NUM_CH = 8;
  localparam int CH_W   = 3;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 5;

  logic                     clk = 1'b0;
  logic                     reset;
  logic [NUM_CH*DATA_W-1:0] ch_samples;
  logic                     sample_valid;
  logic [CH_W-1:0]          ch_sel;
  logic [DATA_W-1:0]        trig_level;
  logic                     trig_edge;
  logic [1:0]               mode;
  logic                     rearm;
  logic                     arm;
  logic [ADDR_W-1:0]        rd_addr;
  logic [DATA_W-1:0]        rd_data;
  logic [9:0]               rd_row;
  logic [1:0]               state;
  logic                     capture_done;
  logic                     auto_trig;

  multi_ch_trigger_capture #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .CH_W(CH_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W),
    .PRE_TRIG(4), .AUTO_TIMEOUT(8), .SCREEN_H(480), .Y_SHIFT(3)
  ) dut (
    .clk(clk), .reset(reset), .ch_samples(ch_samples), .sample_valid(sample_valid),
    .ch_sel(ch_sel), .trig_level(trig_level), .trig_edge(trig_edge), .mode(mode),
    .rearm(rearm), .arm(arm), .rd_addr(rd_addr), .rd_data(rd_data), .rd_row(rd_row),
    .state(state), .capture_done(capture_done), .auto_trig(auto_trig)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
    logic [9:0]        row;
  } rd_vec_t;

  rd_vec_t vecs[$];
  rd_vec_t exp_q[$];
  int      sent[$];
  int      n_vec = 0;
  int      n_err = 0;
  int      done_cnt = 0;

  always @(negedge clk) if (capture_done === 1'b1) done_cnt++;

  function automatic logic [9:0] row_of(input int d);
    int s;
    s = d >> 3;
    if (s > 479) s = 479;
    return 10'(479 - s);
  endfunction

  task automatic check(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  function automatic logic [NUM_CH*DATA_W-1:0] noise();
    logic [NUM_CH*DATA_W-1:0] v;
    for (int c = 0; c < NUM_CH; c++) v[c*DATA_W +: DATA_W] = DATA_W'($urandom);
    return v;
  endfunction

  task automatic send(input int ch, input int val);
    logic [NUM_CH*DATA_W-1:0] v;
    v = noise();
    v[ch*DATA_W +: DATA_W] = DATA_W'(val);
    @(negedge clk);
    ch_samples   = v;
    sample_valid = 1'b1;
    @(negedge clk);
    sample_valid = 1'b0;
    ch_samples   = noise();
    @(negedge clk);
    sent.push_back(val);
  endtask

  task automatic do_reset(input int ch, input int lvl, input logic edg, input logic [1:0] md);
    @(negedge clk);
    reset = 1'b1; sample_valid = 1'b0; rearm = 1'b0; arm = 1'b0; rd_addr = '0;
    ch_sel = CH_W'(ch); trig_level = DATA_W'(lvl); trig_edge = edg; mode = md;
    @(negedge clk);
    @(negedge clk);
    check("rst_state", int'(state), int'(ST_PREFILL));
    check("rst_done", int'(capture_done), 0);
    check("rst_auto", int'(auto_trig), 0);
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_rd_row", int'(rd_row), 479);
    reset = 1'b0;
    // Scramble live config: the capture must keep using the values latched at reset.
    ch_sel = CH_W'(ch + 1); trig_level = 12'hFFF; trig_edge = ~edg; mode = ~md;
    sent.delete();
  endtask

  task automatic read_check(input string tag);
    rd_vec_t e;
    exp_q.delete();
    for (int i = 0; i <= vecs.size(); i++) begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check($sformatf("%s_data[%0d]", tag, e.addr), int'(rd_data), int'(e.data));
        check($sformatf("%s_row[%0d]", tag, e.addr), int'(rd_row), int'(e.row));
      end
      if (i < vecs.size()) begin
        rd_addr = vecs[i].addr;
        exp_q.push_back(vecs[i]);
      end
    end
  endtask

  task automatic add_vec(input int a, input int d);
    vecs.push_back('{ADDR_W'(a), DATA_W'(d), row_of(d)});
  endtask

  task automatic window_from_sent();
    vecs.delete();
    for (int i = 0; i < DEPTH; i++) add_vec(i, sent[sent.size() - DEPTH + i]);
  endtask

  task automatic pulse(input bit is_arm, input bit is_rearm);
    @(negedge clk);
    arm = is_arm; rearm = is_rearm;
    @(negedge clk);
    arm = 1'b0; rearm = 1'b0;
  endtask

  int d0;

  initial begin
    reset = 1'b1; ch_samples = '0; sample_valid = 1'b0; ch_sel = '0; trig_level = '0;
    trig_edge = 1'b0; mode = MODE_NORMAL; rearm = 1'b0; arm = 1'b0; rd_addr = '0;

    // Rising trigger, normal mode, channel 2 ramp
    do_reset(2, 450, EDGE_RISING, MODE_NORMAL);
    for (int k = 0; k < 4; k++) send(2, k * 100);
    check("t1_armed", int'(state), int'(ST_ARMED));
    send(2, 400);
    check("t1_no_trig_400", int'(state), int'(ST_ARMED));
    send(2, 500);
    check("t1_post", int'(state), int'(ST_POST));
    d0 = done_cnt;
    for (int k = 6; k < 16; k++) send(2, k * 100);
    check("t1_still_post", int'(state), int'(ST_POST));
    check("t1_no_early_done", done_cnt - d0, 0);
    send(2, 1600);
    check("t1_hold", int'(state), int'(ST_HOLD));
    check("t1_done_once", done_cnt - d0, 1);
    vecs.delete();
    for (int i = 0; i < DEPTH; i++) add_vec(i, 100 * (i + 1));
    read_check("t1");
    send(2, 4095); send(2, 4095);
    vecs.delete();
    add_vec(0, 100); add_vec(4, 500); add_vec(15, 1600);
    read_check("t1_frozen");
    pulse(1'b1, 1'b0);
    check("t1_arm_ignored", int'(state), int'(ST_HOLD));
    pulse(1'b0, 1'b1);
    check("t1_rearm_exit", int'(state), int'(ST_PREFILL));

    // Falling trigger on channel 5, other channels noisy
    do_reset(5, 3550, EDGE_FALLING, MODE_NORMAL);
    for (int k = 0; k < 6; k++) send(5, 4000 - 100 * k);
    check("t2_post", int'(state), int'(ST_POST));
    for (int k = 6; k < 17; k++) send(5, 4000 - 100 * k);
    check("t2_hold", int'(state), int'(ST_HOLD));
    vecs.delete();
    for (int i = 0; i < DEPTH; i++) add_vec(i, 3900 - 100 * i);
    read_check("t2");

    // Auto timeout with flat input
    do_reset(0, 'h800, EDGE_RISING, MODE_AUTO);
    for (int k = 0; k < 11; k++) send(0, 'h100);
    check("t3_armed", int'(state), int'(ST_ARMED));
    check("t3_auto_clear", int'(auto_trig), 0);
    send(0, 'h100);
    check("t3_forced", int'(state), int'(ST_POST));
    check("t3_auto_set", int'(auto_trig), 1);
    for (int k = 0; k < 11; k++) send(0, 'h100);
    check("t3_hold", int'(state), int'(ST_HOLD));
    check("t3_auto_held", int'(auto_trig), 1);
    do_reset(0, 'h800, EDGE_RISING, MODE_NORMAL);
    for (int k = 0; k < 44; k++) send(0, 'h100);
    check("t3_normal_armed", int'(state), int'(ST_ARMED));
    check("t3_normal_auto", int'(auto_trig), 0);

    // Long ARMED phase so the trigger address wraps
    do_reset(1, 2000, EDGE_RISING, MODE_NORMAL);
    for (int k = 0; k < 44; k++) send(1, k * 10);
    check("t4_armed", int'(state), int'(ST_ARMED));
    send(1, 3000);
    check("t4_post", int'(state), int'(ST_POST));
    for (int k = 0; k < 11; k++) send(1, 3001 + k);
    check("t4_hold", int'(state), int'(ST_HOLD));
    window_from_sent();
    add_vec(4, 3000);
    add_vec(16, 0);
    add_vec(31, 0);
    read_check("t4");

    // Single mode: rearm ignored, arm releases; strobe on exit cycle dropped
    do_reset(3, 1000, EDGE_RISING, MODE_SINGLE);
    for (int k = 0; k < 17; k++) send(3, 200 * k);
    check("t5_hold", int'(state), int'(ST_HOLD));
    for (int r = 0; r < 3; r++) begin
      pulse(1'b0, 1'b1);
      check($sformatf("t5_rearm%0d", r), int'(state), int'(ST_HOLD));
    end
    vecs.delete();
    for (int i = 0; i < DEPTH; i++) add_vec(i, 200 * (i + 1));
    read_check("t5");
    @(negedge clk);
    arm = 1'b1; sample_valid = 1'b1; ch_samples = noise();
    @(negedge clk);
    arm = 1'b0; sample_valid = 1'b0;
    check("t5_arm_exit", int'(state), int'(ST_PREFILL));
    for (int k = 0; k < 3; k++) send(3, 7);
    check("t5_exit_strobe_dropped", int'(state), int'(ST_PREFILL));
    send(3, 7);
    check("t5_prefill_done", int'(state), int'(ST_ARMED));

    // Row mapping extremes, then reset during POST
    do_reset(0, 'h800, EDGE_RISING, MODE_NORMAL);
    send(0, 0); send(0, 'hFFF); send(0, 0); send(0, 0);
    send(0, 'h900);
    for (int k = 0; k < 11; k++) send(0, 'h400);
    check("t6_hold", int'(state), int'(ST_HOLD));
    window_from_sent();
    vecs.push_back('{ADDR_W'(1), DATA_W'('hFFF), 10'd0});
    vecs.push_back('{ADDR_W'(0), DATA_W'(0), 10'd479});
    read_check("t6");
    do_reset(0, 'h800, EDGE_RISING, MODE_NORMAL);
    for (int k = 0; k < 4; k++) send(0, 0);
    send(0, 'h900);
    for (int k = 0; k < 3; k++) send(0, 'h400);
    check("t6_in_post", int'(state), int'(ST_POST));
    rd_addr = ADDR_W'(1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("t6_midpost_state", int'(state), int'(ST_PREFILL));
    check("t6_midpost_done", int'(capture_done), 0);
    check("t6_midpost_row", int'(rd_row), 479);
    reset = 1'b0;
    @(negedge clk);
    check("t6_after_reset", int'(state), int'(ST_PREFILL));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
